// File: rtl/bus_pkg.sv
// Shared definitions for the datapath bus: default width, released-bus value
// and the conventional register slot assignments.
package bus_pkg;

    localparam int DATA_W = 16;

    localparam logic [DATA_W-1:0] BUS_Z = {DATA_W{1'bz}};

    localparam int REG_PC  = 0;
    localparam int REG_SP  = 1;
    localparam int REG_ACC = 2;
    localparam int REG_TMP = 3;

endpackage

// File: rtl/bus_reg_cell.sv
// One bus register: loads from the bus, or counts up/down in place.
// A load always wins over a count on the same edge.
module bus_reg_cell #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             latch,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             wrap_pulse
);

    logic count_up;
    logic count_dn;

    assign count_up = inc & ~dec & ~latch;
    assign count_dn = dec & ~inc & ~latch;

    // Wrap is flagged only for a count that actually takes effect this edge.
    assign wrap_pulse = (count_up && (q == {WIDTH{1'b1}})) ||
                        (count_dn && (q == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (latch) begin
            q <= din;
        end else if (count_up) begin
            q <= q + WIDTH'(1);
        end else if (count_dn) begin
            q <= q - WIDTH'(1);
        end
    end

endmodule

// File: rtl/bus_register_file.sv
// Bank of bus registers on one shared tri-state DATA bus, with in-place
// up/down counting, a sticky wrap flag and a flat debug view of all contents.
module bus_register_file
    import bus_pkg::*;
#(
    parameter int               WIDTH     = DATA_W,
    parameter int               NUM_REGS  = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      reset,
    inout  wire  [WIDTH-1:0]          DATA,
    input  logic                      latch,
    input  logic [ADDR_W-1:0]         latch_sel,
    input  logic                      enable,
    input  logic [ADDR_W-1:0]         enable_sel,
    input  logic                      inc,
    input  logic                      dec,
    input  logic [ADDR_W-1:0]         cnt_sel,
    output logic                      wrap,
    output logic [NUM_REGS*WIDTH-1:0] REG_OUT
);

    logic [NUM_REGS-1:0] latch_oh;
    logic [NUM_REGS-1:0] cnt_oh;
    logic [NUM_REGS-1:0] enable_oh;
    logic [NUM_REGS-1:0] wrap_pulse;
    logic [WIDTH-1:0]    q [NUM_REGS];
    logic [WIDTH-1:0]    drive_val;
    logic                drive_en;
    logic                wrap_q;

    // Indices at or above NUM_REGS match no slot, so they decode to nothing.
    always_comb begin
        latch_oh  = '0;
        cnt_oh    = '0;
        enable_oh = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            latch_oh[i]  = latch  && (latch_sel  == ADDR_W'(i));
            cnt_oh[i]    = (inc || dec) && (cnt_sel == ADDR_W'(i));
            enable_oh[i] = enable && (enable_sel == ADDR_W'(i));
        end
    end

    always_comb begin
        drive_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (enable_oh[i]) begin
                drive_val = drive_val | q[i];
            end
        end
    end

    assign drive_en = (|enable_oh) && !reset;
    assign DATA     = drive_en ? drive_val : {WIDTH{BUS_Z[0]}};

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
        bus_reg_cell #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_cell (
            .clk        (clk),
            .reset      (reset),
            .latch      (latch_oh[g]),
            .inc        (inc && cnt_oh[g]),
            .dec        (dec && cnt_oh[g]),
            .din        (DATA),
            .q          (q[g]),
            .wrap_pulse (wrap_pulse[g])
        );
        assign REG_OUT[g*WIDTH +: WIDTH] = q[g];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else if (|wrap_pulse) begin
            wrap_q <= 1'b1;
        end
    end

    assign wrap = wrap_q;

endmodule
